// File: rtl/fp_sqrt_ctrl.sv
// Binary32 square-root control stage: classifies the operand, resolves specials,
// feeds the shared integer square-root engine and rounds/packs its root.
module fp_sqrt_ctrl #(
    parameter int SQ_W = 50
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [31:0]     a_i,
    input  logic [2:0]      rm_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [31:0]     result_o,
    output logic [4:0]      flags_o,
    output logic            sq_start_o,
    output logic [SQ_W-1:0] sq_n_o,
    input  logic [SQ_W-1:0] sq_q_i,
    input  logic [SQ_W-1:0] sq_r_i,
    input  logic            sq_valid_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Zero, subnormal, inf, NaN and any negative operand never reach the engine.
    function automatic logic is_special(input logic [31:0] a);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) || a[31];
    endfunction

    // Returns {flags, result} for a special operand; subnormals flush to signed zero.
    function automatic logic [36:0] special_pack(input logic [31:0] a);
        logic [36:0] r;
        r = {5'b00000, a};
        if ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) begin
            r = {~a[22], 4'b0000, 32'h7FC0_0000};
        end else if (a[30:23] == 8'd0) begin
            r = {5'b00000, a[31], 31'd0};
        end else if (a[31]) begin
            r = {5'b10000, 32'h7FC0_0000};
        end else begin
            r = {5'b00000, a};
        end
        return r;
    endfunction

    // An odd biased exponent already halves evenly, so the mantissa sits one bit lower.
    function automatic logic [SQ_W-1:0] radicand(input logic [31:0] a);
        logic [24:0]     mext;
        logic [SQ_W-1:0] n;
        mext = a[23] ? {1'b0, 1'b1, a[22:0]} : {1'b1, a[22:0], 1'b0};
        n = '0;
        n[49:0] = {mext, 25'd0};
        return n;
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [2:0]      rm_q, rm_d;
    logic [24:0]     root_q, root_d;
    logic            sticky_q, sticky_d;
    logic [SQ_W-1:0] sq_n_q, sq_n_d;
    logic            sq_start_q, sq_start_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [31:0]     result_q, result_d;
    logic [4:0]      flags_q, flags_d;

    logic            guard_s, lsb_s, inc_s, nx_s;
    logic [8:0]      exp_sum_s;
    logic [7:0]      exp_base_s, exp_r_s;
    logic [23:0]     mant_sum_s;
    logic [22:0]     mant_r_s;
    logic [31:0]     round_res_s;
    logic            unused_s;

    assign unused_s = ^{sq_q_i[SQ_W-1:25], root_q[24]};

    // Rounding and packing of the latched root; the result is always positive.
    always_comb begin
        guard_s   = root_q[0];
        lsb_s     = root_q[1];
        nx_s      = guard_s | sticky_q;
        case (rm_q)
            3'd1, 3'd2: inc_s = 1'b0;
            3'd3:       inc_s = guard_s | sticky_q;
            3'd4:       inc_s = guard_s;
            default:    inc_s = guard_s & (sticky_q | lsb_s);
        endcase
        exp_sum_s  = {1'b0, a_q[30:23]} + (a_q[23] ? 9'd127 : 9'd126);
        exp_base_s = exp_sum_s[8:1];
        mant_sum_s = {1'b0, root_q[23:1]} + {23'd0, inc_s};
        if (mant_sum_s[23]) begin
            exp_r_s  = exp_base_s + 8'd1;
            mant_r_s = 23'd0;
        end else begin
            exp_r_s  = exp_base_s;
            mant_r_s = mant_sum_s[22:0];
        end
        round_res_s = {1'b0, exp_r_s, mant_r_s};
    end

    // Next-state and next-output logic of the control FSM.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        rm_d       = rm_q;
        root_d     = root_q;
        sticky_d   = sticky_q;
        sq_n_d     = sq_n_q;
        sq_start_d = 1'b0;
        result_d   = result_q;
        flags_d    = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d        = a_i;
                    rm_d       = rm_i;
                    sq_n_d     = radicand(a_i);
                    sq_start_d = ~is_special(a_i);
                    state_d    = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (is_special(a_q)) begin
                    {flags_d, result_d} = special_pack(a_q);
                    state_d             = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sq_valid_i) begin
                    root_d   = sq_q_i[24:0];
                    sticky_d = |sq_r_i;
                    state_d  = S_ROUND;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ROUND: begin
                result_d = round_res_s;
                flags_d  = {4'b0000, nx_s};
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            a_q        <= 32'd0;
            rm_q       <= 3'd0;
            root_q     <= 25'd0;
            sticky_q   <= 1'b0;
            sq_n_q     <= '0;
            sq_start_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= 32'd0;
            flags_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            rm_q       <= rm_d;
            root_q     <= root_d;
            sticky_q   <= sticky_d;
            sq_n_q     <= sq_n_d;
            sq_start_q <= sq_start_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign flags_o    = flags_q;
    assign sq_start_o = sq_start_q;
    assign sq_n_o     = sq_n_q;

endmodule

// File: tb/tb_fp_sqrt_ctrl.sv
// Directed bench for fp_sqrt_ctrl; the bench itself plays the integer sqrt engine.
module tb_fp_sqrt_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [31:0] a_i;
    logic [2:0]  rm_i;
    logic        busy_o, valid_o, sq_start_o, sq_valid_i;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic [49:0] sq_n_o, sq_q_i, sq_r_i;

    int checks   = 0;
    int failures = 0;

    fp_sqrt_ctrl #(.SQ_W(50)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .a_i        (a_i),
        .rm_i       (rm_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .flags_o    (flags_o),
        .sq_start_o (sq_start_o),
        .sq_n_o     (sq_n_o),
        .sq_q_i     (sq_q_i),
        .sq_r_i     (sq_r_i),
        .sq_valid_i (sq_valid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] isqrt(input logic [63:0] n);
        logic [63:0] res, t;
        res = 64'd0;
        for (int b = 26; b >= 0; b--) begin
            t = res | (64'd1 << b);
            if (t * t <= n) res = t;
        end
        return res;
    endfunction

    // Normal-path operation; ovr forces the engine root to ovr_q with zero remainder.
    task automatic run_normal(input string tag, input logic [31:0] a, input logic [2:0] rm,
                              input logic [49:0] exp_n, input int lat, input bit hold,
                              input bit ovr, input logic [49:0] ovr_q,
                              input logic [31:0] exp_res, input logic [4:0] exp_fl);
        logic [63:0] q, r;
        @(negedge clk_i);
        start_i = 1'b1; a_i = a; rm_i = rm;
        @(negedge clk_i);
        if (!hold) start_i = 1'b0;
        chk({tag, "_sqstart"}, {63'd0, sq_start_o}, 64'd1);
        chk({tag, "_sqn"}, {14'd0, sq_n_o}, {14'd0, exp_n});
        q = ovr ? {14'd0, ovr_q} : isqrt({14'd0, exp_n});
        r = ovr ? 64'd0 : ({14'd0, exp_n} - q * q);
        for (int i = 0; i < lat; i++) @(negedge clk_i);
        chk({tag, "_sqstart_low"}, {63'd0, sq_start_o}, 64'd0);
        sq_valid_i = 1'b1; sq_q_i = q[49:0]; sq_r_i = r[49:0];
        @(negedge clk_i);
        sq_valid_i = 1'b0;
        chk({tag, "_round_novalid"}, {62'd0, busy_o, valid_o}, 64'd2);
        @(negedge clk_i);
        if (hold) start_i = 1'b0;
        chk({tag, "_valid"}, {63'd0, valid_o}, 64'd1);
        chk({tag, "_res"}, {32'd0, result_o}, {32'd0, exp_res});
        chk({tag, "_flags"}, {59'd0, flags_o}, {59'd0, exp_fl});
        @(negedge clk_i);
        chk({tag, "_idle"}, {62'd0, busy_o, valid_o}, 64'd0);
        chk({tag, "_hold"}, {32'd0, result_o}, {32'd0, exp_res});
    endtask

    task automatic run_special(input string tag, input logic [31:0] a,
                               input logic [31:0] exp_res, input logic [4:0] exp_fl);
        @(negedge clk_i);
        start_i = 1'b1; a_i = a; rm_i = 3'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_check"}, {61'd0, busy_o, valid_o, sq_start_o}, 64'd4);
        @(negedge clk_i);
        chk({tag, "_valid"}, {62'd0, valid_o, sq_start_o}, 64'd2);
        chk({tag, "_res"}, {32'd0, result_o}, {32'd0, exp_res});
        chk({tag, "_flags"}, {59'd0, flags_o}, {59'd0, exp_fl});
        @(negedge clk_i);
        chk({tag, "_idle"}, {62'd0, busy_o, valid_o}, 64'd0);
    endtask

    initial begin
        reset_i = 1'b0; start_i = 1'b0; a_i = 32'd0; rm_i = 3'd0;
        sq_valid_i = 1'b0; sq_q_i = 50'd0; sq_r_i = 50'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_ctrl", {61'd0, busy_o, valid_o, sq_start_o}, 64'd0);
        chk("rst_data", {5'd0, flags_o, result_o, 22'd0}, 64'd0);
        chk("rst_sqn", {14'd0, sq_n_o}, 64'd0);
        reset_i = 1'b1;

        run_normal("four",   32'h4080_0000, 3'd0, 50'h1_0000_0000_0000, 1, 1'b0, 1'b0, 50'd0, 32'h4000_0000, 5'h00);
        run_normal("two_rne", 32'h4000_0000, 3'd0, 50'h2_0000_0000_0000, 3, 1'b0, 1'b0, 50'd0, 32'h3FB5_04F3, 5'h01);
        run_normal("two_rtz", 32'h4000_0000, 3'd1, 50'h2_0000_0000_0000, 2, 1'b0, 1'b0, 50'd0, 32'h3FB5_04F3, 5'h01);
        run_normal("two_rup", 32'h4000_0000, 3'd3, 50'h2_0000_0000_0000, 2, 1'b0, 1'b0, 50'd0, 32'h3FB5_04F4, 5'h01);
        run_normal("two_rdn", 32'h4000_0000, 3'd2, 50'h2_0000_0000_0000, 2, 1'b0, 1'b0, 50'd0, 32'h3FB5_04F3, 5'h01);
        run_normal("two_rmm", 32'h4000_0000, 3'd4, 50'h2_0000_0000_0000, 2, 1'b0, 1'b0, 50'd0, 32'h3FB5_04F3, 5'h01);
        run_normal("nine",   32'h4110_0000, 3'd0, 50'h2_4000_0000_0000, 4, 1'b0, 1'b0, 50'd0, 32'h4040_0000, 5'h00);
        run_normal("one",    32'h3F80_0000, 3'd0, 50'h1_0000_0000_0000, 1, 1'b0, 1'b0, 50'd0, 32'h3F80_0000, 5'h00);
        run_normal("carry",  32'h3F80_0000, 3'd0, 50'h1_0000_0000_0000, 2, 1'b0, 1'b1, 50'h1FF_FFFF, 32'h4000_0000, 5'h01);

        run_special("neg_one", 32'hBF80_0000, 32'h7FC0_0000, 5'h10);
        run_special("neg_inf", 32'hFF80_0000, 32'h7FC0_0000, 5'h10);
        run_special("snan",    32'h7F80_0001, 32'h7FC0_0000, 5'h10);
        run_special("qnan",    32'h7FC0_0001, 32'h7FC0_0000, 5'h00);
        run_special("neg_zero", 32'h8000_0000, 32'h8000_0000, 5'h00);
        run_special("pos_inf", 32'h7F80_0000, 32'h7F80_0000, 5'h00);
        run_special("subn",    32'h0000_0001, 32'h0000_0000, 5'h00);
        run_special("neg_subn", 32'h8000_0001, 32'h8000_0000, 5'h00);

        for (int lat = 1; lat <= 20; lat++)
            run_normal("sweep", 32'h4080_0000, 3'd0, 50'h1_0000_0000_0000, lat, 1'b1, 1'b0, 50'd0, 32'h4000_0000, 5'h00);

        // spurious engine completion while idle
        @(negedge clk_i);
        sq_valid_i = 1'b1; sq_q_i = 50'h1FF_FFFF; sq_r_i = 50'd1;
        @(negedge clk_i);
        sq_valid_i = 1'b0;
        @(negedge clk_i);
        chk("spur_idle", {62'd0, busy_o, valid_o}, 64'd0);
        chk("spur_res", {32'd0, result_o}, 64'h4000_0000);

        // reset while waiting on the engine
        @(negedge clk_i);
        start_i = 1'b1; a_i = 32'h4000_0000; rm_i = 3'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
        reset_i = 1'b0;
        #1;
        chk("mid_rst_ctrl", {61'd0, busy_o, valid_o, sq_start_o}, 64'd0);
        chk("mid_rst_data", {5'd0, flags_o, result_o, 22'd0}, 64'd0);
        chk("mid_rst_sqn", {14'd0, sq_n_o}, 64'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        sq_valid_i = 1'b1; sq_q_i = 50'h16A_09E6; sq_r_i = 50'd5;
        @(negedge clk_i);
        sq_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("post_rst_quiet", {62'd0, busy_o, valid_o}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_ctrl.md
# fp_sqrt_ctrl

Single-precision (IEEE-754 binary32) square-root control stage that wraps the shared integer square-root unit. It unpacks and classifies the operand, resolves special cases locally, and builds the parity-adjusted radicand. It issues that radicand to the integer root engine, then consumes the root and remainder to round and pack the result with exception flags. It sits between the FPU operand dispatch and the integer square-root engine, and owns both the feed and the consume side of that engine.

## Interface
- `SQ_W`, default 50: integer-sqrt width, even; root occupies `sq_q_i[SQ_W/2-1:0]`.
- `clk_i`  in  1  clock, rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  operation request; sampled only in IDLE.
- `a_i`  in  32  operand, binary32.
- `rm_i`  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others behave as RNE.
- `busy_o`  out  1  high whenever state is not IDLE.
- `valid_o`  out  1  one-cycle completion pulse.
- `result_o`  out  32  packed result; holds until the next completion.
- `flags_o`  out  5  {NV,DZ,OF,UF,NX}; holds with `result_o`.
- `sq_start_o`  out  1  start pulse to the integer sqrt engine.
- `sq_n_o`  out  SQ_W  radicand to the engine.
- `sq_q_i`  in  SQ_W  root from the engine.
- `sq_r_i`  in  SQ_W  remainder from the engine.
- `sq_valid_i`  in  1  engine completion pulse.

## Operation
- FSM states: IDLE, CHECK, WAIT, ROUND, DONE.
  - IDLE to CHECK on `start_i`. `a_i` and `rm_i` are latched at that edge.
  - CHECK to DONE if the operand is special, with the result registered.
  - CHECK to WAIT otherwise. `sq_start_o` = 1 for exactly the CHECK cycle.
  - WAIT to ROUND on `sq_valid_i`. `sq_q_i` and `sq_r_i` are latched at that edge.
  - ROUND to DONE, with the result registered.
  - DONE to IDLE unconditionally.
- `start_i` is ignored outside IDLE. `sq_valid_i` is ignored outside WAIT.
- Subnormal inputs flush to zero with sign kept. FTZ is not an exception and raises no flag.
- Special cases (DZ, OF and UF are always 0):
  - Any NaN gives 0x7FC00000; NV is set only for sNaN.
  - A negative nonzero operand, including -inf, gives 0x7FC00000 with NV.
  - ±0 gives ±0.
  - +inf gives 0x7F800000.
- Radicand for finite positive normals:
  - `Mext` is 25 bits: E odd gives {0,1,m}; E even gives {1,m,0}.
  - `sq_n_o` = `Mext` << 25, zero-padded to SQ_W. It is registered and stable from CHECK through WAIT.
- Exponent: result E = (E+127)>>1 if E odd, (E+126)>>1 if E even.
- Root fields: root = `sq_q_i[24:0]`, taken as bit24 hidden, bits 23:1 mantissa, bit0 guard. Sticky = |`sq_r_i`.
- Rounding (result always positive):
  - RNE: increment if guard & (sticky | lsb).
  - RTZ and RDN: never increment.
  - RUP: increment if guard | sticky.
  - RMM: increment if guard.
- NX = guard | sticky.
- Mantissa carry-out on increment: mantissa becomes 0 and exponent +1. This case must be handled even though it is unreachable.

## Timing
- Reset values: `valid_o`, `busy_o`, `sq_start_o` = 0; `result_o`, `flags_o`, `sq_n_o` = 0; state IDLE.
- Reset mid-operation aborts the operation immediately. No `valid_o` follows, and a late `sq_valid_i` is ignored.
- Special path: start sampled at edge k gives CHECK at k+1 and `valid_o` high in cycle k+2.
- Normal path: `sq_start_o` is high in cycle k+1. `sq_valid_i` sampled at edge j gives ROUND at j, with `valid_o` high in cycle j+1.
- Back-to-back: the earliest next `start_i` is sampled in the cycle after DONE.
- `result_o` and `flags_o` update at the edge entering DONE, so they are valid when `valid_o` = 1.

## Test plan
- 0x40800000 (4.0), RNE gives 0x40000000, flags 0, exact (`sq_r_i` = 0).
- 0x40000000 (2.0): RNE gives 0x3FB504F3, NX; RTZ gives 0x3FB504F3; RUP gives 0x3FB504F4. All with NX set.
- 0xBF800000 gives 0x7FC00000, NV, with `sq_start_o` never asserted and `valid_o` two cycles after start. 0x7F800001 (sNaN) gives 0x7FC00000, NV. 0x7FC00001 gives 0x7FC00000, flags 0.
- 0x80000000 gives 0x80000000. 0x7F800000 gives 0x7F800000. 0x00000001 (subnormal) gives 0x00000000, flags 0.
- Engine latency swept 1 to 20 cycles: `valid_o` lands exactly 2 cycles after the `sq_valid_i` edge. `start_i` held high during busy is ignored, and spurious `sq_valid_i` in IDLE is ignored.
- `reset_i` low during WAIT: all outputs go to 0 at once, and no `valid_o` after release even if `sq_valid_i` arrives.
